// File: rtl/mux_arb_reg.sv
// N-channel WIDTH-bit selector with a registered output stage.
// Mode 0 selects channel sel explicitly; mode 1 arbitrates round-robin among valid channels.
module mux_arb_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready,
  output logic                 err_sel
);

  // Handshake: a beat moves when valid && ready on the same rising edge; ready never
  // depends on the same channel's data, and valid on one side never waits for ready.

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             sel_ok;
  logic             rr_found;
  logic [SELW-1:0]  rr_grant;
  logic [SELW-1:0]  src_sel;
  logic             cand_ok;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  int               idx;

  always_comb begin
    load_ok  = !flush && (!out_valid_q || out_ready);
    sel_ok   = (int'(sel) < N);
    rr_found = 1'b0;
    rr_grant = '0;
    idx      = 0;
    // Walk from the farthest offset back to ptr so the nearest valid channel wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (i == idx && in_valid[i]) begin
          rr_found = 1'b1;
          rr_grant = SELW'(i);
        end
      end
    end

    src_sel  = mode ? rr_grant : sel;
    cand_ok  = mode ? rr_found : sel_ok;
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == src_sel) begin
        in_ready[i] = rst_n && load_ok && cand_ok;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
    xfer = |(in_ready & in_valid);
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    if (flush) begin
      out_valid_d = 1'b0;
      ptr_d       = '0;
      err_d       = 1'b0;
    end else begin
      if (xfer) begin
        out_data_d  = sel_data;
        out_src_d   = src_sel;
        out_valid_d = 1'b1;
        if (mode) ptr_d = (int'(rr_grant) == N - 1) ? '0 : rr_grant + SELW'(1);
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      if (!mode && !sel_ok && load_ok) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      ptr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign err_sel   = err_q;

endmodule
